// File: rtl/extbus_pkg.sv
// Shared types and defaults for the four-port word/tag register file.
package extbus_pkg;
  typedef enum logic [1:0] {PORT_A, PORT_B, PORT_C, PORT_X} port_e;

  localparam int NPORT = 4;
  localparam int DEF_DW = 64;
  localparam int DEF_TW = 8;
  localparam int DEF_DEPTH = 4;

  // Highest-priority writer first.
  localparam port_e PRIO [NPORT] = '{PORT_X, PORT_C, PORT_B, PORT_A};

  function automatic int tw_eff(int tw);
    return (tw > 0) ? tw : 1;
  endfunction
endpackage

// File: rtl/extbus_rf_if.sv
// Port bundle of extbus_rf: four write/read ports plus collision status.
interface extbus_rf_if #(
  parameter int DW = extbus_pkg::DEF_DW,
  parameter int TW = extbus_pkg::DEF_TW,
  parameter int DEPTH = extbus_pkg::DEF_DEPTH,
  parameter int AW = $clog2(DEPTH)
);
  import extbus_pkg::*;
  localparam int TWI = tw_eff(TW);

  logic [DW-1:0] DA, DB, DC, DX;
  logic [TWI-1:0] TB, TC, TX;
  logic [AW-1:0] AA, AB, AC, AX;
  logic ECA, ECB, ECC, ECX;
  logic ECBTAG, ECCTAG, ECXTAG;
  logic WA, WB, WC, WX;
  logic clr_err;
  logic [DW-1:0] oDA, oDB, oDC, oDX;
  logic [TWI-1:0] oTB, oTC, oTX;
  logic collide, collide_sticky;

  modport master (
    output DA, DB, DC, DX, TB, TC, TX,
    output AA, AB, AC, AX,
    output ECA, ECB, ECC, ECX,
    output ECBTAG, ECCTAG, ECXTAG,
    output WA, WB, WC, WX, clr_err,
    input  oDA, oDB, oDC, oDX,
    input  oTB, oTC, oTX,
    input  collide, collide_sticky
  );

  modport slave (
    input  DA, DB, DC, DX, TB, TC, TX,
    input  AA, AB, AC, AX,
    input  ECA, ECB, ECC, ECX,
    input  ECBTAG, ECCTAG, ECXTAG,
    input  WA, WB, WC, WX, clr_err,
    output oDA, oDB, oDC, oDX,
    output oTB, oTC, oTX,
    output collide, collide_sticky
  );
endinterface

// File: rtl/extbus_wsel.sv
// Per-field write resolver: winning writer per word and collision flag.
module extbus_wsel #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic [extbus_pkg::NPORT-1:0]         we,
  input  logic [extbus_pkg::NPORT-1:0][AW-1:0] addr,
  input  logic [extbus_pkg::NPORT-1:0][W-1:0]  data,
  output logic [DEPTH-1:0]                     wen,
  output logic [DEPTH-1:0][W-1:0]              wdata,
  output logic                                 coll
);
  import extbus_pkg::*;

  int p;

  // Walk lowest priority first so the strongest writer lands last.
  always_comb begin
    wen = '0;
    wdata = '0;
    coll = 1'b0;
    p = 0;
    for (int w = 0; w < DEPTH; w++) begin
      for (int i = NPORT - 1; i >= 0; i--) begin
        p = int'(PRIO[i]);
        if (we[p] && addr[p] == AW'(w)) begin
          if (wen[w]) coll = 1'b1;
          wen[w] = 1'b1;
          wdata[w] = data[p];
        end
      end
    end
  end
endmodule

// File: rtl/extbus_rf.sv
// Four-port flop-based register file, data + optional tag field per word.
module extbus_rf #(
  parameter int DW = extbus_pkg::DEF_DW,
  parameter int TW = extbus_pkg::DEF_TW,
  parameter int DEPTH = extbus_pkg::DEF_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset_n,
  extbus_rf_if.slave bus
);
  import extbus_pkg::*;
  localparam int TWI = tw_eff(TW);

  logic [NPORT-1:0] wr, ed, et;
  logic [NPORT-1:0][AW-1:0] ad;
  logic [NPORT-1:0][DW-1:0] wd;
  logic [NPORT-1:0][TWI-1:0] wt;

  assign wr = {bus.WX, bus.WC, bus.WB, bus.WA};
  assign ed = {bus.ECX, bus.ECC, bus.ECB, bus.ECA};
  assign et = {bus.ECXTAG, bus.ECCTAG, bus.ECBTAG, 1'b0};
  assign ad = {bus.AX, bus.AC, bus.AB, bus.AA};
  assign wd = {bus.DX, bus.DC, bus.DB, bus.DA};
  assign wt = {bus.TX, bus.TC, bus.TB, TWI'(0)};

  logic [DEPTH-1:0][DW-1:0] mem_d, wdat_d, nxt_d;
  logic [DEPTH-1:0] wen_d;
  logic [NPORT-1:0][DW-1:0] od;
  logic [NPORT-1:0][TWI-1:0] ot;
  logic coll_d, coll_t;
  logic collide_q, sticky_q;

  extbus_wsel #(.W(DW), .DEPTH(DEPTH), .AW(AW)) u_wsel_d (
    .we(wr & ed), .addr(ad), .data(wd),
    .wen(wen_d), .wdata(wdat_d), .coll(coll_d)
  );

  // Readers see this cycle's winning write (write-first).
  always_comb begin
    nxt_d = mem_d;
    for (int i = 0; i < DEPTH; i++)
      if (wen_d[i]) nxt_d[i] = wdat_d[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_d <= '0;
      od <= '0;
    end else begin
      mem_d <= nxt_d;
      for (int p = 0; p < NPORT; p++)
        if (ed[p]) od[p] <= wr[p] ? wd[p] : nxt_d[ad[p]];
    end
  end

  if (TW > 0) begin : g_tag
    logic [DEPTH-1:0][TWI-1:0] mem_t, wdat_t, nxt_t;
    logic [DEPTH-1:0] wen_t;

    extbus_wsel #(.W(TWI), .DEPTH(DEPTH), .AW(AW)) u_wsel_t (
      .we(wr & et), .addr(ad), .data(wt),
      .wen(wen_t), .wdata(wdat_t), .coll(coll_t)
    );

    always_comb begin
      nxt_t = mem_t;
      for (int i = 0; i < DEPTH; i++)
        if (wen_t[i]) nxt_t[i] = wdat_t[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mem_t <= '0;
        ot <= '0;
      end else begin
        mem_t <= nxt_t;
        for (int p = 1; p < NPORT; p++)
          if (et[p]) ot[p] <= wr[p] ? wt[p] : nxt_t[ad[p]];
      end
    end
  end else begin : g_notag
    assign ot = '0;
    assign coll_t = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collide_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      collide_q <= coll_d | coll_t;
      sticky_q <= coll_d | coll_t | (sticky_q & ~bus.clr_err);
    end
  end

  assign bus.oDA = od[PORT_A];
  assign bus.oDB = od[PORT_B];
  assign bus.oDC = od[PORT_C];
  assign bus.oDX = od[PORT_X];
  assign bus.oTB = ot[PORT_B];
  assign bus.oTC = ot[PORT_C];
  assign bus.oTX = ot[PORT_X];
  assign bus.collide = collide_q;
  assign bus.collide_sticky = sticky_q;
endmodule

// File: tb/tb_extbus_rf.sv
// Directed + random check of extbus_rf against a word-level behavioural model.
module tb_extbus_rf;
  localparam int DW = 64;
  localparam int TW = 8;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  extbus_rf_if #(.DW(DW), .TW(TW), .DEPTH(DEPTH), .AW(AW)) bus ();

  extbus_rf #(.DW(DW), .TW(TW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  logic w [4], ed [4], et [4];
  logic [AW-1:0] a [4];
  logic [DW-1:0] d [4];
  logic [TW-1:0] t [4];
  logic clr;

  assign bus.DA = d[0];
  assign bus.DB = d[1];
  assign bus.DC = d[2];
  assign bus.DX = d[3];
  assign bus.TB = t[1];
  assign bus.TC = t[2];
  assign bus.TX = t[3];
  assign bus.AA = a[0];
  assign bus.AB = a[1];
  assign bus.AC = a[2];
  assign bus.AX = a[3];
  assign bus.ECA = ed[0];
  assign bus.ECB = ed[1];
  assign bus.ECC = ed[2];
  assign bus.ECX = ed[3];
  assign bus.ECBTAG = et[1];
  assign bus.ECCTAG = et[2];
  assign bus.ECXTAG = et[3];
  assign bus.WA = w[0];
  assign bus.WB = w[1];
  assign bus.WC = w[2];
  assign bus.WX = w[3];
  assign bus.clr_err = clr;

  logic [DW-1:0] md [DEPTH];
  logic [TW-1:0] mt [DEPTH];
  logic [DW-1:0] exp_od [4];
  logic [TW-1:0] exp_ot [4];
  logic exp_col, exp_st;
  logic armed = 1'b0;
  int nvec = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic clear_vec();
    for (int p = 0; p < 4; p++) begin
      w[p] = 1'b0; ed[p] = 1'b0; et[p] = 1'b0;
      a[p] = '0; d[p] = '0; t[p] = '0;
    end
    clr = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      md[i] = '0; mt[i] = '0;
    end
    for (int p = 0; p < 4; p++) begin
      exp_od[p] = '0; exp_ot[p] = '0;
    end
    exp_col = 1'b0;
    exp_st = 1'b0;
  endtask

  // Count writers per word and field; later (stronger) ports overwrite.
  task automatic model_step();
    logic c;
    int n;
    c = 1'b0;
    for (int wd = 0; wd < DEPTH; wd++) begin
      n = 0;
      for (int p = 0; p < 4; p++)
        if (ed[p] && w[p] && int'(a[p]) == wd) begin
          n++; md[wd] = d[p];
        end
      if (n > 1) c = 1'b1;
      n = 0;
      for (int p = 1; p < 4; p++)
        if (et[p] && w[p] && int'(a[p]) == wd) begin
          n++; mt[wd] = t[p];
        end
      if (n > 1) c = 1'b1;
    end
    for (int p = 0; p < 4; p++) begin
      if (ed[p]) exp_od[p] = w[p] ? d[p] : md[a[p]];
      if (p > 0 && et[p]) exp_ot[p] = w[p] ? t[p] : mt[a[p]];
    end
    exp_st = c | (exp_st & ~clr);
    exp_col = c;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
    clear_vec();
  endtask

  always @(posedge clk) begin
    if (armed && reset_n) begin
      #1;
      chk("oDA", bus.oDA, exp_od[0]);
      chk("oDB", bus.oDB, exp_od[1]);
      chk("oDC", bus.oDC, exp_od[2]);
      chk("oDX", bus.oDX, exp_od[3]);
      chk("oTB", DW'(bus.oTB), DW'(exp_ot[1]));
      chk("oTC", DW'(bus.oTC), DW'(exp_ot[2]));
      chk("oTX", DW'(bus.oTX), DW'(exp_ot[3]));
      chk("collide", DW'(bus.collide), DW'(exp_col));
      chk("sticky", DW'(bus.collide_sticky), DW'(exp_st));
    end
  end

  task automatic chk_all_zero(string tagname);
    chk({tagname, "_oDA"}, bus.oDA, '0);
    chk({tagname, "_oDB"}, bus.oDB, '0);
    chk({tagname, "_oDC"}, bus.oDC, '0);
    chk({tagname, "_oDX"}, bus.oDX, '0);
    chk({tagname, "_oTB"}, DW'(bus.oTB), '0);
    chk({tagname, "_oTC"}, DW'(bus.oTC), '0);
    chk({tagname, "_oTX"}, DW'(bus.oTX), '0);
    chk({tagname, "_col"}, DW'(bus.collide), '0);
    chk({tagname, "_sticky"}, DW'(bus.collide_sticky), '0);
  endtask

  initial begin
    clear_vec();
    model_reset();
    // Enables toggling during reset must be ignored.
    w[0] = 1'b1; ed[0] = 1'b1; d[0] = 64'h55;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    clear_vec();
    reset_n = 1'b1;
    armed = 1'b1;

    // Write via A, read back via B.
    w[0] = 1'b1; ed[0] = 1'b1; a[0] = 2'd1; d[0] = 64'h0123456789ABCDEF;
    step();
    ed[1] = 1'b1; et[1] = 1'b1; a[1] = 2'd1;
    step();
    chk("rd_oDB", bus.oDB, 64'h0123456789ABCDEF);
    chk("rd_oTB", DW'(bus.oTB), '0);

    // Three-way collision on word 2.
    for (int p = 0; p < 4; p++) if (p != 2) begin
      w[p] = 1'b1; ed[p] = 1'b1; a[p] = 2'd2;
    end
    d[0] = 64'h1; d[1] = 64'h2; d[3] = 64'h3;
    step();
    chk("col_pulse", DW'(bus.collide), DW'(1));
    chk("col_sticky", DW'(bus.collide_sticky), DW'(1));
    ed[2] = 1'b1; a[2] = 2'd2;
    step();
    chk("col_drop", DW'(bus.collide), '0);
    chk("col_hold", DW'(bus.collide_sticky), DW'(1));
    chk("win_oDC", bus.oDC, 64'h3);
    clr = 1'b1;
    step();
    chk("clr_sticky", DW'(bus.collide_sticky), '0);

    // Data from B, tag from X on word 0: different fields, no collision.
    w[1] = 1'b1; ed[1] = 1'b1; a[1] = 2'd0; d[1] = 64'hBEEF;
    w[3] = 1'b1; et[3] = 1'b1; a[3] = 2'd0; t[3] = 8'h5A;
    step();
    chk("split_col", DW'(bus.collide), '0);
    ed[2] = 1'b1; et[2] = 1'b1; a[2] = 2'd0;
    step();
    chk("split_oDC", bus.oDC, 64'hBEEF);
    chk("split_oTC", DW'(bus.oTC), DW'(8'h5A));

    // Write-first bypass: C writes word 3 while A reads it.
    w[2] = 1'b1; ed[2] = 1'b1; a[2] = 2'd3; d[2] = 64'hDEAD;
    ed[0] = 1'b1; a[0] = 2'd3;
    step();
    chk("byp_oDA", bus.oDA, 64'hDEAD);

    // Collision together with clr_err: set wins.
    w[0] = 1'b1; ed[0] = 1'b1; a[0] = 2'd1; d[0] = 64'hAA;
    w[1] = 1'b1; ed[1] = 1'b1; a[1] = 2'd1; d[1] = 64'hBB;
    clr = 1'b1;
    step();
    chk("setwin", DW'(bus.collide_sticky), DW'(1));
    clr = 1'b1;
    step();
    chk("clr2", DW'(bus.collide_sticky), '0);

    // Tag-only collision, C beats B; then read it back.
    w[1] = 1'b1; et[1] = 1'b1; a[1] = 2'd2; t[1] = 8'h11;
    w[2] = 1'b1; et[2] = 1'b1; a[2] = 2'd2; t[2] = 8'h22;
    step();
    et[3] = 1'b1; a[3] = 2'd2;
    step();
    chk("tagwin_oTX", DW'(bus.oTX), DW'(8'h22));

    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 4; p++) begin
        w[p] = 1'($urandom_range(0, 1));
        ed[p] = 1'($urandom_range(0, 1));
        et[p] = (p > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        a[p] = AW'($urandom_range(0, DEPTH - 1));
        d[p] = {$urandom, $urandom};
        t[p] = TW'($urandom);
      end
      clr = ($urandom_range(0, 7) == 0);
      step();
    end

    // Fill every word, then reset mid-cycle on top of a pending write.
    for (int i = 0; i < DEPTH; i++) begin
      w[3] = 1'b1; ed[3] = 1'b1; et[3] = 1'b1; a[3] = AW'(i);
      d[3] = 64'hF0 + 64'(i); t[3] = TW'(8'hC0 + i);
      step();
    end
    w[0] = 1'b1; ed[0] = 1'b1; a[0] = 2'd0; d[0] = 64'h77;
    armed = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async");
    model_reset();
    clear_vec();
    @(negedge clk);
    reset_n = 1'b1;
    armed = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ed[1] = 1'b1; et[1] = 1'b1; a[1] = AW'(i);
      ed[3] = 1'b1; et[3] = 1'b1; a[3] = AW'(i);
      step();
      chk("post_rst_oDX", bus.oDX, '0);
    end

    armed = 1'b0;
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
